static_control_loader: RTL
==========================

Name: static_control_loader

Overview:
- Sequencer directly upstream of the bank of static control flip-flops. Each flip-flop latches its din on the rising edge of its own set_trigger.
- Converts single-bit and whole-word load requests from the host endpoint logic into per-bit din/set strobes. Timing is glitch-safe: din is stable before the strobe rises and held after it falls.
- Keeps a shadow copy of every control bit, so ctrl_din for bits that are not being loaded never moves.

Parameters:
- NUM_CTRL, 16, number of static control bits driven (1..2^ADDR_W).
- ADDR_W, 4, width of the single-bit address.
- SETUP_CYC, 2, clk cycles din is stable before the strobe rises (>=1).
- STROBE_CYC, 4, clk cycles the strobe is held high (>=1).

Ports:
- clk, input, 1, system clock; all logic on its rising edge.
- rst, input, 1, synchronous active-high reset.
- load_req, input, 1, single-cycle pulse: load one bit.
- load_addr, input, ADDR_W, bit index for load_req.
- load_value, input, 1, value for load_req.
- load_all, input, 1, single-cycle pulse: load every bit from load_word.
- load_word, input, NUM_CTRL, values for load_all; bit i goes to control i.
- ctrl_din, output, NUM_CTRL, shadow values; feeds the din of each control flop.
- ctrl_set, output, NUM_CTRL, per-bit set_trigger strobes; at most one bit high.
- busy, output, 1, sequence in progress.
- done, output, 1, one-cycle pulse when a sequence completes.
- err, output, 1, one-cycle pulse: address out of range or request dropped.

Behaviour:
- Reset: synchronous, active-high.
  - Next edge with rst=1 forces state IDLE, ctrl_din=0, ctrl_set=0, busy=0, done=0, err=0, index=0.
  - rst mid-sequence aborts immediately: ctrl_set falls at that edge and no done is issued.
- FSM states: IDLE, SETUP, STROBE, HOLD, NEXT.
- IDLE, request sampled at edge T:
  - load_all has priority over load_req when both are high.
  - load_req with load_addr<NUM_CTRL: latch addr, single mode. At T+1: ctrl_din[addr]=load_value, busy=1, go to SETUP.
  - load_req with load_addr>=NUM_CTRL: err=1 at T+1, nothing else changes, stay IDLE.
  - load_all: latch load_word, index=0, bulk mode. At T+1: ctrl_din[0]=load_word[0], busy=1, go to SETUP.
- Per-bit sequence for bit k:
  - SETUP: lasts SETUP_CYC cycles; ctrl_set=0.
  - STROBE: ctrl_set[k]=1 for STROBE_CYC cycles.
  - HOLD: 1 cycle, ctrl_set=0, ctrl_din unchanged.
  - NEXT: in bulk mode with k<NUM_CTRL-1, k+1 and ctrl_din[k+1] update at the HOLD exit edge, then SETUP again. Otherwise done=1 and busy=0 at that edge, go to IDLE.
  - Per-bit cost is SETUP_CYC+STROBE_CYC+1 cycles.
- Defaults, single load sampled at T:
  - ctrl_set[addr] high for cycles T+3..T+6.
  - HOLD at T+7.
  - done=1 and busy=0 at T+8.
- Defaults, bulk load: done at T+1+16*7 = T+113.
- Requests while busy=1 are dropped: err pulses the cycle after, and the sequence in flight is unaffected.
- ctrl_din bits not under load keep their shadow value. ctrl_din[k] changes only at the entry edge of SETUP for k.
- ctrl_set is registered and never glitches. Two ctrl_set bits are never high in the same cycle.
- Reloading a bit with its current value still issues the full strobe.
- Counters are sized to hold max(SETUP_CYC, STROBE_CYC) and NUM_CTRL-1; no wrap occurs within a sequence.

Test Plan:
- Reset then single load, load_req at T with addr=5, value=1 -> ctrl_din[5]=1 at T+1; ctrl_set=16'h0020 for T+3..T+6 and 0 elsewhere; done at T+8; ctrl_din=16'h0020.
- load_all with load_word=16'hA5C3 -> 16 one-hot strobes in order bit0..bit15, each 4 cycles high at a 7-cycle pitch; done at T+113; final ctrl_din=16'hA5C3; ctrl_din[k] never changes while ctrl_set[k]=1.
- load_req with addr=3 at T+2 during that bulk load -> err pulse at T+3; strobe sequence and final ctrl_din unchanged.
- load_req addr=15 and load_all (word=16'h0001) in the same cycle -> bulk wins; no single-bit sequence; final ctrl_din=16'h0001.
- NUM_CTRL=12, load_req addr=13 -> err=1 for one cycle; busy stays 0; ctrl_set stays 0.
- rst asserted at T+4 of a single load to addr=2 -> ctrl_set=0 and ctrl_din=0 from T+5; no done; a new load_req at T+6 completes normally.

Source files
------------

// File: rtl/static_control_loader.sv
// Load sequencer for the static control flip-flop bank.
// Turns bit/word load requests into glitch-safe per-bit din/set strobes.
module static_control_loader #(
  parameter int NUM_CTRL   = 16,
  parameter int ADDR_W     = 4,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_req,
  input  logic [ADDR_W-1:0]   load_addr,
  input  logic                load_value,
  input  logic                load_all,
  input  logic [NUM_CTRL-1:0] load_word,
  output logic [NUM_CTRL-1:0] ctrl_din,
  output logic [NUM_CTRL-1:0] ctrl_set,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int MAX_CYC =
    (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int CNT_W = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST =
    CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LAST =
    CNT_W'(STROBE_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    NEXT
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [ADDR_W-1:0]   idx_q;
  logic [ADDR_W-1:0]   idx_d;
  logic                bulk_q;
  logic                bulk_d;
  logic [NUM_CTRL-1:0] word_q;
  logic [NUM_CTRL-1:0] word_d;
  logic [NUM_CTRL-1:0] din_q;
  logic [NUM_CTRL-1:0] din_d;
  logic [NUM_CTRL-1:0] set_q;
  logic [NUM_CTRL-1:0] set_d;
  logic                busy_q;
  logic                busy_d;
  logic                done_q;
  logic                done_d;
  logic                err_q;
  logic                err_d;

  logic [NUM_CTRL-1:0] onehot;
  logic [ADDR_W-1:0]   nxt_idx;
  logic                addr_ok;
  logic                more_bits;
  logic                any_req;

  // Request qualification and per-bit helpers.
  always_comb begin
    onehot        = '0;
    onehot[idx_q] = 1'b1;
    nxt_idx       = idx_q + ADDR_W'(1);
    addr_ok       = int'(load_addr) < NUM_CTRL;
    more_bits     = bulk_q &&
                    (int'(idx_q) < NUM_CTRL - 1);
    any_req       = load_req || load_all;
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    bulk_d  = bulk_q;
    word_d  = word_q;
    din_d   = din_q;
    set_d   = '0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (load_all) begin
          word_d   = load_word;
          idx_d    = '0;
          bulk_d   = 1'b1;
          din_d[0] = load_word[0];
          busy_d   = 1'b1;
          cnt_d    = '0;
          state_d  = SETUP;
        end else if (load_req) begin
          if (addr_ok) begin
            idx_d            = load_addr;
            bulk_d           = 1'b0;
            din_d[load_addr] = load_value;
            busy_d           = 1'b1;
            cnt_d            = '0;
            state_d          = SETUP;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          set_d   = onehot;
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STROBE: begin
        if (cnt_q == STROBE_LAST) begin
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          set_d = onehot;
        end
      end

      // The advance decision is taken on the HOLD exit edge,
      // so NEXT costs no cycle of its own.
      HOLD: begin
        if (more_bits) begin
          idx_d          = nxt_idx;
          din_d[nxt_idx] = word_q[nxt_idx];
          cnt_d          = '0;
          state_d        = SETUP;
        end else begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          bulk_d  = 1'b0;
          state_d = IDLE;
        end
      end

      NEXT: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (state_q != IDLE && any_req) begin
      err_d = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      bulk_q  <= 1'b0;
      word_q  <= '0;
      din_q   <= '0;
      set_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      bulk_q  <= bulk_d;
      word_q  <= word_d;
      din_q   <= din_d;
      set_q   <= set_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ctrl_din = din_q;
  assign ctrl_set = set_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
